// File: rtl/dpram_port_arbiter_pkg.sv
// Shared constants and types for the dual-port RAM request arbiter.
//   AW/DW/CW : default address, data and collision-counter widths
//   DEPTH    : RAM depth implied by AW
//   port_sel_t : identifies client A (RAM port 1) or client B (RAM port 2)
package dpram_port_arbiter_pkg;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        PortA = 1'b0,
        PortB = 1'b1
    } port_sel_t;

    function automatic port_sel_t other_port(port_sel_t p);
        return (p == PortA) ? PortB : PortA;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// One client's request/response bundle towards the arbiter.
//   valid/ready : request handshake, request fires when both are high
//   we          : 1 = write, 0 = read
//   addr/wdata  : request address and write data
//   rvalid/rdata: read response, exactly one cycle after a read fires
// master = client side, slave = arbiter side.
interface dpram_port_arbiter_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 32
);
    logic          valid;
    logic          ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/dpram_port_arbiter_rsp_pipe.sv
// Per-port read response stage: registers "a read fired" for one cycle and
// zero-gates the RAM's registered output so rdata is 0 whenever rvalid is low.
//   clk, rst     : clock, asynchronous active-high reset
//   rd_fire_i    : a read request fired this cycle
//   ram_dout_i   : RAM registered read data for this port
//   rvalid_o     : response valid, one cycle after the read fired
//   rdata_o      : response data (0 when not valid)
module dpram_port_arbiter_rsp_pipe #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_fire_i,
    input  logic [DW-1:0] ram_dout_i,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o
);

    logic rvalid_q, rvalid_d;

    always_comb begin
        rvalid_d = rd_fire_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        rvalid_o = rvalid_q;
        rdata_o  = rvalid_q ? ram_dout_i : '0;
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Request front-end for the 8x32 dual-port RAM. Client A drives RAM port 1,
// client B drives RAM port 2. Same-address write/write collisions are resolved
// round-robin; the losing client sees ready=0 and must hold its request.
//   clk, rst          : clock, asynchronous active-high reset
//   a_if, b_if        : client request/response bundles (slave side)
//   ram_wen*/addr*/din*: RAM port drive
//   ram_dout1/2_i     : RAM registered read data
//   conflict_cnt_o    : saturating count of collision cycles
module dpram_port_arbiter
    import dpram_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = dpram_port_arbiter_pkg::AW,
    parameter int unsigned DW = dpram_port_arbiter_pkg::DW,
    parameter int unsigned CW = dpram_port_arbiter_pkg::CW
) (
    input  logic                 clk,
    input  logic                 rst,
    dpram_port_arbiter_if.slave  a_if,
    dpram_port_arbiter_if.slave  b_if,
    output logic                 ram_wen1_o,
    output logic [AW-1:0]        ram_addr1_o,
    output logic [DW-1:0]        ram_din1_o,
    output logic                 ram_wen2_o,
    output logic [AW-1:0]        ram_addr2_o,
    output logic [DW-1:0]        ram_din2_o,
    input  logic [DW-1:0]        ram_dout1_i,
    input  logic [DW-1:0]        ram_dout2_i,
    output logic [CW-1:0]        conflict_cnt_o
);

    port_sel_t     rr_q, rr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          collision;
    logic          a_fire, b_fire;

    always_comb begin
        collision = a_if.valid & b_if.valid & a_if.we & b_if.we & (a_if.addr == b_if.addr);

        // Ready does not depend on valid except through a collision.
        a_if.ready = ~rst & (~collision | (rr_q == PortA));
        b_if.ready = ~rst & (~collision | (rr_q == PortB));

        a_fire = a_if.valid & a_if.ready;
        b_fire = b_if.valid & b_if.ready;

        ram_wen1_o  = a_fire & a_if.we;
        ram_addr1_o = a_if.addr;
        ram_din1_o  = a_if.wdata;
        ram_wen2_o  = b_fire & b_if.we;
        ram_addr2_o = b_if.addr;
        ram_din2_o  = b_if.wdata;

        rr_d  = rr_q;
        cnt_d = cnt_q;
        if (collision) begin
            rr_d = other_port(rr_q);
            if (cnt_q != {CW{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        conflict_cnt_o = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q  <= PortA;
            cnt_q <= '0;
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
        end
    end

    dpram_port_arbiter_rsp_pipe #(
        .DW(DW)
    ) u_rsp_a (
        .clk       (clk),
        .rst       (rst),
        .rd_fire_i (a_fire & ~a_if.we),
        .ram_dout_i(ram_dout1_i),
        .rvalid_o  (a_if.rvalid),
        .rdata_o   (a_if.rdata)
    );

    dpram_port_arbiter_rsp_pipe #(
        .DW(DW)
    ) u_rsp_b (
        .clk       (clk),
        .rst       (rst),
        .rd_fire_i (b_fire & ~b_if.we),
        .ram_dout_i(ram_dout2_i),
        .rvalid_o  (b_if.rvalid),
        .rdata_o   (b_if.rdata)
    );

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural read-before-write
// 8x32 dual-port RAM attached to the arbiter's RAM pins.
module tb_dpram_port_arbiter;
    import dpram_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dpram_port_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
    dpram_port_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

    logic          ram_wen1, ram_wen2;
    logic [AW-1:0] ram_addr1, ram_addr2;
    logic [DW-1:0] ram_din1, ram_din2;
    logic [DW-1:0] ram_dout1 = '0;
    logic [DW-1:0] ram_dout2 = '0;
    logic [CW-1:0] conflict_cnt;

    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    dpram_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .a_if          (a_if),
        .b_if          (b_if),
        .ram_wen1_o    (ram_wen1),
        .ram_addr1_o   (ram_addr1),
        .ram_din1_o    (ram_din1),
        .ram_wen2_o    (ram_wen2),
        .ram_addr2_o   (ram_addr2),
        .ram_din2_o    (ram_din2),
        .ram_dout1_i   (ram_dout1),
        .ram_dout2_i   (ram_dout2),
        .conflict_cnt_o(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Registered reads see the old contents when the same edge writes.
    always @(posedge clk) begin
        if (ram_wen1) mem[ram_addr1] <= ram_din1;
        if (ram_wen2) mem[ram_addr2] <= ram_din2;
        ram_dout1 <= mem[ram_addr1];
        ram_dout2 <= mem[ram_addr2];
    end

    typedef struct {
        logic          av, awe;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv, bwe;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          ar, br;     // expected readies in this cycle
        logic          arv;        // expected responses after the edge
        logic [DW-1:0] ard;
        logic          brv;
        logic [DW-1:0] brd;
        logic [CW-1:0] cnt;        // expected counter after the edge
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(int av, int awe, int aa, logic [31:0] ad,
                                int bv, int bwe, int ba, logic [31:0] bd,
                                int ar, int br, int arv, logic [31:0] ard,
                                int brv, logic [31:0] brd, int cnt);
        vec_t v;
        v.av  = (av != 0);
        v.awe = (awe != 0);
        v.aa  = AW'(aa);
        v.ad  = ad;
        v.bv  = (bv != 0);
        v.bwe = (bwe != 0);
        v.ba  = AW'(ba);
        v.bd  = bd;
        v.ar  = (ar != 0);
        v.br  = (br != 0);
        v.arv = (arv != 0);
        v.ard = ard;
        v.brv = (brv != 0);
        v.brd = brd;
        v.cnt = CW'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [AW-1:0] ad,
                           input logic [DW-1:0] d);
        a_if.valid = v;
        a_if.we    = we;
        a_if.addr  = ad;
        a_if.wdata = d;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [AW-1:0] ad,
                           input logic [DW-1:0] d);
        b_if.valid = v;
        b_if.we    = we;
        b_if.addr  = ad;
        b_if.wdata = d;
    endtask

    initial begin
        //           A: v we a data           B: v we a data           rdy  A rsp            B rsp            cnt
        vecs[0]  = mk(1, 1, 2, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,          1, 1, 0, 32'h0,       0, 32'h0,       0);
        vecs[1]  = mk(1, 0, 2, 32'h0,         0, 0, 0, 32'h0,          1, 1, 1, 32'hDEAD_BEEF, 0, 32'h0,     0);
        vecs[2]  = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 1, 0, 32'h0,       0, 32'h0,       0);
        vecs[3]  = mk(1, 1, 5, 32'h1111,      1, 1, 5, 32'h2222,       1, 0, 0, 32'h0,       0, 32'h0,       1);
        vecs[4]  = mk(0, 0, 0, 32'h0,         1, 1, 5, 32'h2222,       1, 1, 0, 32'h0,       0, 32'h0,       1);
        vecs[5]  = mk(1, 0, 5, 32'h0,         0, 0, 0, 32'h0,          1, 1, 1, 32'h2222,    0, 32'h0,       1);
        vecs[6]  = mk(1, 1, 5, 32'h3333,      1, 1, 5, 32'h4444,       0, 1, 0, 32'h0,       0, 32'h0,       2);
        vecs[7]  = mk(1, 1, 5, 32'h3333,      0, 0, 0, 32'h0,          1, 1, 0, 32'h0,       0, 32'h0,       2);
        vecs[8]  = mk(1, 0, 5, 32'h0,         1, 0, 5, 32'h0,          1, 1, 1, 32'h3333,    1, 32'h3333,    2);
        vecs[9]  = mk(0, 0, 0, 32'h0,         1, 1, 3, 32'h11,         1, 1, 0, 32'h0,       0, 32'h0,       2);
        vecs[10] = mk(1, 0, 3, 32'h0,         1, 1, 3, 32'h55,         1, 1, 1, 32'h11,      0, 32'h0,       2);
        vecs[11] = mk(1, 0, 3, 32'h0,         0, 0, 0, 32'h0,          1, 1, 1, 32'h55,      0, 32'h0,       2);
        vecs[12] = mk(1, 1, 0, 32'hA0A0,      1, 1, 7, 32'hB7B7,       1, 1, 0, 32'h0,       0, 32'h0,       2);
        vecs[13] = mk(1, 1, 1, 32'hA1A1,      1, 1, 6, 32'hB6B6,       1, 1, 0, 32'h0,       0, 32'h0,       2);
        vecs[14] = mk(1, 0, 0, 32'h0,         1, 0, 7, 32'h0,          1, 1, 1, 32'hA0A0,    1, 32'hB7B7,    2);
        vecs[15] = mk(1, 0, 1, 32'h0,         1, 0, 6, 32'h0,          1, 1, 1, 32'hA1A1,    1, 32'hB6B6,    2);
        vecs[16] = mk(1, 0, 2, 32'h0,         1, 0, 5, 32'h0,          1, 1, 1, 32'hDEAD_BEEF, 1, 32'h3333,  2);
        vecs[17] = mk(1, 0, 3, 32'h0,         1, 0, 3, 32'h0,          1, 1, 1, 32'h55,      1, 32'h55,      2);
        vecs[18] = mk(0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 1, 0, 32'h0,       0, 32'h0,       2);

        // Reset state, with a write request presented while rst is high.
        drive_a(1'b1, 1'b1, 3'd1, 32'h99);
        drive_b(1'b1, 1'b0, 3'd1, 32'h0);
        #3;
        check("rst a_ready", 32'(a_if.ready), 32'd0);
        check("rst b_ready", 32'(b_if.ready), 32'd0);
        check("rst ram_wen1", 32'(ram_wen1), 32'd0);
        check("rst a_rvalid", 32'(a_if.rvalid), 32'd0);
        check("rst b_rvalid", 32'(b_if.rvalid), 32'd0);
        check("rst conflict_cnt", 32'(conflict_cnt), 32'd0);
        @(posedge clk);
        #1;
        check("rst hold a_rvalid", 32'(a_if.rvalid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive_a(vecs[i].av, vecs[i].awe, vecs[i].aa, vecs[i].ad);
            drive_b(vecs[i].bv, vecs[i].bwe, vecs[i].ba, vecs[i].bd);
            #1;
            check($sformatf("v%0d a_ready", i), 32'(a_if.ready), 32'(vecs[i].ar));
            check($sformatf("v%0d b_ready", i), 32'(b_if.ready), 32'(vecs[i].br));
            check($sformatf("v%0d ram_wen1", i), 32'(ram_wen1),
                  32'(vecs[i].av & vecs[i].awe & vecs[i].ar));
            check($sformatf("v%0d ram_wen2", i), 32'(ram_wen2),
                  32'(vecs[i].bv & vecs[i].bwe & vecs[i].br));
            check($sformatf("v%0d ram_addr1", i), 32'(ram_addr1), 32'(vecs[i].aa));
            @(posedge clk);
            #1;
            check($sformatf("v%0d a_rvalid", i), 32'(a_if.rvalid), 32'(vecs[i].arv));
            check($sformatf("v%0d a_rdata", i), a_if.rdata, vecs[i].ard);
            check($sformatf("v%0d b_rvalid", i), 32'(b_if.rvalid), 32'(vecs[i].brv));
            check($sformatf("v%0d b_rdata", i), b_if.rdata, vecs[i].brd);
            check($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vecs[i].cnt));
        end

        // Reset asserted the cycle after a read fires drops the response at once.
        drive_a(1'b1, 1'b0, 3'd2, 32'h0);
        drive_b(1'b0, 1'b0, 3'd0, 32'h0);
        @(posedge clk);
        #1;
        check("pre-rst a_rvalid", 32'(a_if.rvalid), 32'd1);
        check("pre-rst a_rdata", a_if.rdata, 32'hDEAD_BEEF);
        drive_a(1'b1, 1'b1, 3'd2, 32'hBAD);
        rst = 1'b1;
        #1;
        check("mid-rst a_rvalid", 32'(a_if.rvalid), 32'd0);
        check("mid-rst a_rdata", a_if.rdata, 32'h0);
        check("mid-rst conflict_cnt", 32'(conflict_cnt), 32'd0);
        check("mid-rst a_ready", 32'(a_if.ready), 32'd0);
        check("mid-rst ram_wen1", 32'(ram_wen1), 32'd0);
        @(posedge clk);
        #1;
        check("rst edge a_rvalid", 32'(a_if.rvalid), 32'd0);
        rst = 1'b0;

        // Round-robin pointer is back at A: held collision grants A, then B.
        drive_a(1'b1, 1'b1, 3'd4, 32'h44);
        drive_b(1'b1, 1'b1, 3'd4, 32'h88);
        #1;
        check("post-rst coll a_ready", 32'(a_if.ready), 32'd1);
        check("post-rst coll b_ready", 32'(b_if.ready), 32'd0);
        @(posedge clk);
        #1;
        check("post-rst coll2 a_ready", 32'(a_if.ready), 32'd0);
        check("post-rst coll2 b_ready", 32'(b_if.ready), 32'd1);
        check("post-rst coll cnt", 32'(conflict_cnt), 32'd1);

        // Keep colliding to run the counter into saturation (2**CW+3 cycles total).
        repeat (65533) @(posedge clk);
        #1;
        check("sat cnt FFFE", 32'(conflict_cnt), 32'hFFFE);
        @(posedge clk);
        #1;
        check("sat cnt FFFF", 32'(conflict_cnt), 32'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        check("sat cnt held", 32'(conflict_cnt), 32'hFFFF);

        drive_a(1'b0, 1'b0, 3'd0, 32'h0);
        drive_b(1'b0, 1'b0, 3'd0, 32'h0);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Request front-end that sits directly upstream of the team's 8x32 dual-port RAM (DPort_RAM).
- Accepts independent valid/ready read/write requests from two clients, A and B. A maps to RAM port 1, B to RAM port 2.
- Resolves same-address write-write collisions with round-robin priority.
- Drives the RAM's wen/addr/din pins and returns read data to each client with a fixed one-cycle response valid.

Parameters:
- AW, 3, address width (RAM depth 2**AW = 8)
- DW, 32, data width
- CW, 16, width of saturating collision counter

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- a_valid  in  1  client A request valid
- a_ready  out  1  client A request accepted this cycle
- a_we  in  1  client A write (1) / read (0)
- a_addr  in  AW  client A address
- a_wdata  in  DW  client A write data
- a_rvalid  out  1  client A read data valid
- a_rdata  out  DW  client A read data
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as A, for client B
- ram_wen1  out  1  RAM port 1 write enable
- ram_addr1  out  AW  RAM port 1 address
- ram_din1  out  DW  RAM port 1 write data
- ram_wen2, ram_addr2, ram_din2: same as port 1, for RAM port 2
- ram_dout1  in  DW  RAM port 1 registered read data
- ram_dout2  in  DW  RAM port 2 registered read data
- conflict_cnt  out  CW  count of stall cycles caused by collisions

Behaviour:
- Reset (async, rst=1) clears:
  - a_rvalid=0, b_rvalid=0
  - rr_ptr=A
  - conflict_cnt=0
- While rst=1: a_ready=b_ready=0, ram_wen1=ram_wen2=0.
- Fire: x_fire = x_valid & x_ready.
- Collision condition: a_valid & b_valid & a_we & b_we & (a_addr==b_addr).
  - No collision: a_ready=b_ready=1 (combinational, no dependence on valid).
  - Collision: only the rr_ptr side is ready; the other side's ready is 0. The loser must hold its request stable.
  - After a collision cycle, rr_ptr toggles to the other side.
  - rr_ptr is unchanged on non-collision cycles.
  - conflict_cnt increments by 1 per collision cycle and saturates at 2**CW-1.
- Same-address read-read: both clients are granted.
- Same-address read/write across ports: both are granted. The read returns the pre-write (old) data, because the RAM uses read-before-write ordering.
- RAM drive (combinational):
  - ram_wen1 = a_fire & a_we; ram_addr1 = a_addr; ram_din1 = a_wdata.
  - Port 2 is driven identically from client B.
  - An idle port still presents its address; no response is generated for it.
- Read latency:
  - a_rvalid registers (a_fire & ~a_we) and is high exactly one cycle after a read fires.
  - a_rdata = ram_dout1 when a_rvalid, else 0. B is handled identically with ram_dout2.
  - Back-to-back reads give one response per cycle, in order.
  - There is no response backpressure.
- Writes produce no response.
- Reset mid-operation: any pending rvalid is dropped and no response is issued for a request fired in the cycle rst asserts. The first request is accepted on the first clk edge after rst deasserts.

Decomposition:
- Package dpram_pkg:
  - AW/DW/DEPTH constants
  - port_sel_t enum {PORT_A, PORT_B} used for rr_ptr
- One natural sub-module, dpram_rsp_pipe: per-port 1-cycle read-valid register plus the rdata zero-gating. Instantiated twice.
- Arbitration and counter stay in the top module.

Test Plan:
- Write A addr2=32'hDEAD_BEEF, then read A addr2 -> a_ready=1 both cycles; a_rvalid=1 one cycle after the read fires with a_rdata=32'hDEAD_BEEF; no rvalid after the write.
- A and B both write addr5 (A=32'h1111, B=32'h2222) with valids held:
  - Cycle 0: only a_ready=1.
  - Cycle 1: only b_ready=1.
  - Then: readback of addr5=32'h2222, conflict_cnt=1.
  - Repeating the collision grants B first.
- A reads addr3 while B writes addr3=32'h55 (old value 32'h11) in the same cycle -> both ready; a_rdata=32'h11 next cycle; a later read returns 32'h55.
- Simultaneous reads A addr0, B addr7, sustained 4 cycles with changing addresses -> a_rvalid/b_rvalid high 4 consecutive cycles with matching data, in order.
- Assert rst in the cycle after a read fires -> a_rvalid=0 immediately, conflict_cnt=0, rr_ptr back to A (verified by a subsequent collision granting A first).
- Force 2**CW+3 collision cycles -> conflict_cnt stays at 16'hFFFF.
